// File: rtl/run_seq_pkg.sv
// run_seq_pkg: shared state encoding and default sizing for the run sequencer.
package run_seq_pkg;
  localparam int DEFAULT_TIME_W = 26;
  localparam int DEFAULT_TIMEOUT = 2 ** 24;
  typedef enum logic [2:0] {IDLE, CLEAR, LAUNCH, RUN, STOP, CAPTURE, DONE} state_t;
endpackage

// File: rtl/run_sequencer_core_done_tracker.sv
// core_done_tracker: sticky per-core done collection over the active mask.
module core_done_tracker #(
  parameter int NUM_CORES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic [NUM_CORES-1:0] activeMask,
  input  logic [NUM_CORES-1:0] coreDone,
  output logic [NUM_CORES-1:0] doneSeen,
  output logic                 allDone
);
  always_ff @(posedge clk or posedge rst)
    if (rst) doneSeen <= '0;
    else if (clr) doneSeen <= '0;
    else if (en) doneSeen <= doneSeen | (coreDone & activeMask);
  // Includes this cycle's done so completion is recognised without an extra cycle.
  assign allDone = (doneSeen | (coreDone & activeMask)) == activeMask;
endmodule

// File: rtl/run_sequencer.sv
// run_sequencer: clears/starts the cycle counter, launches cores, and captures elapsed run time.
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int TIME_W    = DEFAULT_TIME_W,
  parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 runReq,
  input  logic [NUM_CORES-1:0] coreMask,
  input  logic [NUM_CORES-1:0] coreDone,
  input  logic                 ack,
  input  logic [TIME_W-1:0]    timerValue,
  output logic [NUM_CORES-1:0] coreStart,
  output logic                 timerRstN,
  output logic                 timerStart,
  output logic                 timerStop,
  output logic [TIME_W-1:0]    runTime,
  output logic                 busy,
  output logic                 runDone,
  output logic                 timedOut
);
  localparam int WD_W = TIMEOUT > 2 ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);
  if (64'(TIMEOUT) >= (64'd1 << TIME_W)) begin : g_bad_timeout
    $error("TIMEOUT must be below 2**TIME_W");
  end
  state_t state;
  logic [NUM_CORES-1:0] activeMask, doneSeen;
  logic [WD_W-1:0] wdog;
  logic start, allDone;
  assign start = runReq && |coreMask;
  core_done_tracker #(.NUM_CORES(NUM_CORES)) u_tracker (
    .clk(clk),
    .rst(rst),
    .clr(state == IDLE && start),
    .en(state == RUN),
    .activeMask(activeMask),
    .coreDone(coreDone),
    .doneSeen(doneSeen),
    .allDone(allDone)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      activeMask <= '0;
      wdog <= '0;
      timedOut <= 1'b0;
      runTime <= '0;
    end else
      case (state)
        IDLE: if (start) begin
          state <= CLEAR;
          activeMask <= coreMask;
          wdog <= '0;
          timedOut <= 1'b0;
        end
        CLEAR: state <= LAUNCH;
        LAUNCH: state <= RUN;
        RUN: if (allDone || wdog == WD_MAX) state <= STOP;
             else wdog <= wdog + WD_W'(1);
        // Collected set already holds the final RUN cycle, so a short set means the watchdog ended it.
        STOP: begin
          state <= CAPTURE;
          timedOut <= doneSeen != activeMask;
        end
        CAPTURE: begin
          state <= DONE;
          runTime <= timerValue;
        end
        DONE: if (ack) state <= IDLE;
        default: state <= IDLE;
      endcase
  assign coreStart = state == LAUNCH ? activeMask : '0;
  assign timerStart = state == LAUNCH;
  assign timerStop = state == STOP;
  assign timerRstN = !rst && state != CLEAR;
  assign busy = state != IDLE && state != DONE;
  assign runDone = state == DONE;
endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: directed checks of the run sequencer against a behavioural cycle counter.
module tb_run_sequencer;
  localparam int NC = 4;
  localparam int TW = 26;
  logic clk = 0, rst = 1, runReq = 0, runReq8 = 0, ack = 0, sel = 0;
  logic [NC-1:0] coreMask = '0, coreDone = '0;
  logic [NC-1:0] cs_a, cs_b;
  logic rn_a, rn_b, ts_a, ts_b, tp_a, tp_b, by_a, by_b, rd_a, rd_b, to_a, to_b;
  logic [TW-1:0] rt_a, rt_b, cnt_a, cnt_b;
  logic run_a, run_b;
  int passes = 0, fails = 0, total = 0;

  always #5 clk = ~clk;

  run_sequencer #(.NUM_CORES(NC), .TIME_W(TW), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .runReq(runReq), .coreMask(coreMask), .coreDone(coreDone),
    .ack(ack), .timerValue(cnt_a), .coreStart(cs_a), .timerRstN(rn_a), .timerStart(ts_a),
    .timerStop(tp_a), .runTime(rt_a), .busy(by_a), .runDone(rd_a), .timedOut(to_a)
  );
  run_sequencer #(.NUM_CORES(NC), .TIME_W(TW), .TIMEOUT(8)) dut8 (
    .clk(clk), .rst(rst), .runReq(runReq8), .coreMask(coreMask), .coreDone(coreDone),
    .ack(ack), .timerValue(cnt_b), .coreStart(cs_b), .timerRstN(rn_b), .timerStart(ts_b),
    .timerStop(tp_b), .runTime(rt_b), .busy(by_b), .runDone(rd_b), .timedOut(to_b)
  );

  // Counter model: sync clear, counts from the edge after start, freezes on stop.
  always @(posedge clk) begin
    if (!rn_a) begin cnt_a <= '0; run_a <= 0; end
    else begin
      if (tp_a) run_a <= 0; else if (ts_a) run_a <= 1;
      if (run_a && !tp_a) cnt_a <= cnt_a + 1'b1;
    end
    if (!rn_b) begin cnt_b <= '0; run_b <= 0; end
    else begin
      if (tp_b) run_b <= 0; else if (ts_b) run_b <= 1;
      if (run_b && !tp_b) cnt_b <= cnt_b + 1'b1;
    end
  end

  wire [NC-1:0] s_cs = sel ? cs_b : cs_a;
  wire s_rn = sel ? rn_b : rn_a;
  wire s_ts = sel ? ts_b : ts_a;
  wire s_tp = sel ? tp_b : tp_a;
  wire s_by = sel ? by_b : by_a;
  wire s_rd = sel ? rd_b : rd_a;
  wire s_to = sel ? to_b : to_a;
  wire [TW-1:0] s_rt = sel ? rt_b : rt_a;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_run(input logic s, input logic [3:0] m, input int o0, input int o1,
                        input int o2, input int o3, input int n, input logic to, input string tag);
    sel = s;
    coreMask = m;
    if (s) runReq8 = 1; else runReq = 1;
    step();
    runReq = 0;
    runReq8 = 0;
    chk({tag, "_clear_rstn"}, s_rn, 0);
    chk({tag, "_clear_busy"}, s_by, 1);
    step();
    chk({tag, "_launch_start"}, s_cs, m);
    chk({tag, "_launch_tstart"}, s_ts, 1);
    for (int k = 1; k <= n + 2; k++) begin
      step();
      coreDone = {o3 == k, o2 == k, o1 == k, o0 == k};
      if (k == 1) chk({tag, "_start_once"}, {s_cs, s_ts}, 0);
      if (k == n + 1) chk({tag, "_tstop"}, s_tp, 1);
      if (k == n + 2) chk({tag, "_no_early_done"}, s_rd, 0);
    end
    step();
    coreDone = '0;
    chk({tag, "_rundone"}, s_rd, 1);
    chk({tag, "_busy_done"}, s_by, 0);
    chk({tag, "_runtime"}, s_rt, n);
    chk({tag, "_timedout"}, s_to, to);
  endtask

  task automatic do_ack(input string tag);
    ack = 1;
    step();
    ack = 0;
    chk({tag, "_ack_idle"}, {s_rd, s_by}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "bench time limit");
  end

  initial begin
    #1;
    chk("rst_rstn", rn_a, 0);
    chk("rst_outs", {cs_a, ts_a, tp_a, by_a, rd_a, to_a}, 0);
    chk("rst_runtime", rt_a, 0);
    step();
    step();
    rst = 0;
    step();
    chk("idle_rstn", rn_a, 1);
    chk("idle_busy", by_a, 0);

    do_run(0, 4'b1111, 3, 7, 7, 12, 12, 0, "t2");
    step();
    chk("t2_hold_runtime", rt_a, 12);
    do_ack("t2");
    chk("t2_idle_runtime", rt_a, 12);

    do_run(0, 4'b0101, 4, 2, 9, 0, 9, 0, "t3");
    do_ack("t3");

    do_run(0, 4'b0001, 0, 0, 0, 0, 16, 1, "t4");
    do_ack("t4");

    sel = 0;
    coreMask = 4'b1111;
    runReq = 1;
    step();
    runReq = 0;
    step();
    repeat (5) step();
    rst = 1;
    #1;
    chk("t1_rstn_low", rn_a, 0);
    chk("t1_outs", {cs_a, ts_a, tp_a, by_a, rd_a, to_a}, 0);
    chk("t1_runtime", rt_a, 0);
    step();
    rst = 0;
    step();
    chk("t1_idle", {by_a, rn_a}, 2'b01);
    repeat (3) step();
    chk("t1_no_stop", {tp_a, cs_a, by_a}, 0);

    coreMask = '0;
    runReq = 1;
    step();
    chk("t5_zero_mask_busy", by_a, 0);
    step();
    chk("t5_zero_mask_quiet", {by_a, cs_a, ts_a, rn_a}, 1);
    runReq = 0;
    do_run(0, 4'b0010, 0, 1, 0, 0, 1, 0, "t5");
    runReq = 1;
    step();
    chk("t5_req_ignored_in_done", rd_a, 1);
    ack = 1;
    step();
    ack = 0;
    chk("t5_back_idle", {rd_a, by_a}, 0);
    step();
    chk("t5_restart_clear", {by_a, rn_a}, 2'b10);
    runReq = 0;
    rst = 1;
    step();
    rst = 0;
    step();

    do_run(1, 4'b0001, 8, 0, 0, 0, 8, 0, "t6");
    do_ack("t6");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
